// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline registers plus the mult/div busy FSM.
// Optional macro HAZARD_STATS_EN adds a saturating stall-cycle counter on stall_cnt.
module pipe_hazard_ctrl #(
  parameter int RA_W    = 5,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_branch,
  input  logic            id_md_use,
  input  logic            ex_memread,
  input  logic            ex_regwrite,
  input  logic [RA_W-1:0] ex_wa,
  input  logic            mem_memread,
  input  logic [RA_W-1:0] mem_wa,
  input  logic            md_start,
  input  logic            md_is_div,
  input  logic            exc_flush,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_clr,
  output logic            idex_clr,
  output logic            exmem_clr,
  output logic            md_busy,
  output logic [31:0]     stall_cnt
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;
  logic             ex_match, mem_match;
  logic             lu_haz, br_haz, md_haz, stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign ex_match  = (ex_wa != '0) &&
                     ((id_use_rs && (id_rs == ex_wa)) || (id_use_rt && (id_rt == ex_wa)));
  assign mem_match = (mem_wa != '0) &&
                     ((id_use_rs && (id_rs == mem_wa)) || (id_use_rt && (id_rt == mem_wa)));

  assign lu_haz = ex_memread && ex_match;
  assign br_haz = id_branch && ((ex_regwrite && ex_match) || (mem_memread && mem_match));
  assign md_haz = id_md_use && md_busy;
  assign stall  = lu_haz || br_haz || md_haz;

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    if (reset) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (exc_flush) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  // Flush does not abort an in-flight op: HI/LO must still be written.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= IDLE;
      md_cnt   <= '0;
      md_busy  <= 1'b0;
    end else if (md_state == IDLE) begin
      if (md_start && !stall) begin
        md_state <= BUSY;
        md_busy  <= 1'b1;
        md_cnt   <= md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
      end
    end else begin
      if (md_cnt == CNT_W'(1)) begin
        md_state <= IDLE;
        md_busy  <= 1'b0;
        md_cnt   <= '0;
      end else begin
        md_cnt <= md_cnt - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && !exc_flush && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
